// File: rtl/imem_pkg.sv
// Shared types and default geometry for the boot-loading instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } imem_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF  = 1024;
  localparam int OFS_W_DEF      = $clog2(DATA_WIDTH_DEF / BYTE_WIDTH_DEF);
  localparam int WORD_AW_DEF    = $clog2(MEM_DEPTH_DEF);

endpackage

// File: rtl/imem_ram.sv
// 1W1R synchronous word RAM; registered read port that updates only when re is high.
module imem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset so the fetch output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory that zero-fills itself, accepts a streamed program image, then serves checked fetches.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_valid,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         ld_last,
  output logic                         ld_ready,
  input  logic                         reload,
  input  logic                         fetch_req,
  input  logic [ADDR_WIDTH-1:0]        fetch_addr,
  output logic [DATA_WIDTH-1:0]        fetch_rdata,
  output logic                         fetch_valid,
  output logic                         fetch_err,
  output logic                         boot_done,
  output logic [$clog2(MEM_DEPTH):0]   load_count,
  output logic                         load_ovf
);

  localparam int OFS_W   = $clog2(DATA_WIDTH / BYTE_WIDTH);
  localparam int WORD_AW = $clog2(MEM_DEPTH);
  localparam logic [WORD_AW-1:0]  LAST_WORD = WORD_AW'(MEM_DEPTH - 1);
  localparam logic [WORD_AW:0]    FULL_CNT  = (WORD_AW + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / BYTE_WIDTH));

  imem_state_e state, state_nxt;

  logic [WORD_AW-1:0]    clr_cnt;
  logic                  hs, full;
  logic                  we;
  logic [WORD_AW-1:0]    waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  fetch_go, addr_bad, re;
  logic                  rd_zero;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign hs   = (state == ST_LOAD) && ld_valid;
  assign full = (load_count == FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST_WORD) state_nxt = ST_LOAD;
      ST_LOAD:  if (hs && ld_last)         state_nxt = ST_RUN;
      ST_RUN:   if (reload)                state_nxt = ST_CLEAR;
      default:                             state_nxt = ST_CLEAR;
    endcase
  end

  // Write port is shared between the zero-fill sweep and the image stream.
  always_comb begin
    ld_ready  = 1'b0;
    boot_done = 1'b0;
    we        = 1'b0;
    waddr     = clr_cnt;
    wdata     = '0;
    case (state)
      ST_CLEAR: we = 1'b1;
      ST_LOAD: begin
        ld_ready = 1'b1;
        we       = ld_valid && !full;
        waddr    = load_count[WORD_AW-1:0];
        wdata    = ld_data;
      end
      ST_RUN:   boot_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt    <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else begin
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      if (state_nxt == ST_CLEAR) begin
        load_count <= '0;
        load_ovf   <= 1'b0;
      end else if (hs) begin
        if (full) load_ovf   <= 1'b1;
        else      load_count <= load_count + 1'b1;
      end
    end
  end

  assign fetch_go = fetch_req && (state == ST_RUN);
  assign addr_bad = (fetch_addr[OFS_W-1:0] != '0) || ({1'b0, fetch_addr} >= MEM_BYTES);
  assign re       = fetch_go && !addr_bad;

  // rd_zero remembers whether the last completed fetch faulted so rdata holds between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      rd_zero     <= 1'b0;
    end else begin
      fetch_valid <= fetch_go;
      fetch_err   <= fetch_go && addr_bad;
      if (fetch_go) rd_zero <= addr_bad;
    end
  end

  assign fetch_rdata = rd_zero ? '0 : ram_rdata;

  imem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .AW        (WORD_AW)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(fetch_addr[OFS_W+WORD_AW-1:OFS_W]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: fixed vectors plus randomized loads/fetches against an image-queue model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_last, ld_ready, reload;
  logic [31:0] ld_data;
  logic        fetch_req, fetch_valid, fetch_err, boot_done, load_ovf;
  logic [31:0] fetch_addr, fetch_rdata;
  logic [10:0] load_count;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .reload     (reload),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_rdata(fetch_rdata),
    .fetch_valid(fetch_valid),
    .fetch_err  (fetch_err),
    .boot_done  (boot_done),
    .load_count (load_count),
    .load_ovf   (load_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the accepted image words in order; everything else reads as zero.
  logic [31:0] image[$];
  logic        ovf_m;
  logic [31:0] exp_hold;
  logic [31:0] src[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t vecs[13];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(int idx);
    return (idx < image.size()) ? image[idx] : 32'h0;
  endfunction

  function automatic logic ref_err(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    image.delete();
    ovf_m = 1'b0;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ld_ready"},    32'(ld_ready),    32'h0);
    chk({tag, "_fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, "_fetch_rdata"}, fetch_rdata,      32'h0);
    chk({tag, "_fetch_err"},   32'(fetch_err),   32'h0);
    chk({tag, "_boot_done"},   32'(boot_done),   32'h0);
    chk({tag, "_load_count"},  32'(load_count),  32'h0);
    chk({tag, "_load_ovf"},    32'(load_ovf),    32'h0);
  endtask

  // Counts cycles until ld_ready; fetches are attempted throughout and must be ignored.
  task automatic wait_clear(string tag);
    int n = 0;
    logic saw_valid = 1'b0, saw_done = 1'b0;
    while (!ld_ready && n < 1200) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'($urandom_range(0, 1023)) << 2;
      step();
      n++;
      if (fetch_valid) saw_valid = 1'b1;
      if (boot_done)   saw_done  = 1'b1;
    end
    fetch_req = 1'b0;
    chk({tag, "_clear_cycles"}, 32'(n), 32'd1024);
    chk({tag, "_clear_fetch_valid"}, 32'(saw_valid), 32'h0);
    chk({tag, "_clear_boot_done"}, 32'(saw_done), 32'h0);
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles between beats, 2 random idles
  task automatic load_src(input int gap_mode);
    for (int i = 0; i < src.size(); i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? ((i == 0) ? 0 : 2) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        ld_last  = 1'($urandom);
        step();
      end
      ld_valid = 1'b1;
      ld_data  = src[i];
      ld_last  = (i == src.size() - 1);
      step();
      if (image.size() < 1024) image.push_back(src[i]);
      else                     ovf_m = 1'b1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_fetch(string name, logic [31:0] a, logic [31:0] exp_d, logic exp_e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
    exp_hold   = exp_d;
    chk({name, "_valid"}, 32'(fetch_valid), 32'h1);
    chk({name, "_rdata"}, fetch_rdata, exp_d);
    chk({name, "_err"},   32'(fetch_err), 32'(exp_e));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    model_clear();
  endtask

  task automatic rand_fetch(input int n);
    for (int c = 0; c < n; c++) begin
      logic        req;
      logic [31:0] a;
      int          r;
      req = ($urandom_range(0, 2) != 0);
      r   = $urandom_range(0, 7);
      if (r == 0)      a = (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'($urandom_range(32'd4096, 32'hFFFF_FFF0));
      else if (r < 5)  a = 32'($urandom_range(0, image.size() + 2)) << 2;
      else             a = 32'($urandom_range(0, 1023)) << 2;
      fetch_req  = req;
      fetch_addr = a;
      step();
      if (req) begin
        exp_hold = ref_err(a) ? 32'h0 : ref_word(int'(a >> 2));
        chk("rnd_valid", 32'(fetch_valid), 32'h1);
        chk("rnd_err",   32'(fetch_err),   32'(ref_err(a)));
      end else begin
        chk("rnd_idle_valid", 32'(fetch_valid), 32'h0);
      end
      chk("rnd_rdata", fetch_rdata, exp_hold);
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    exp_hold = '0;
    model_clear();

    vecs[0]  = '{32'd36, 32'h0000006F, 1'b0};
    vecs[1]  = '{32'd0,  32'h00000513, 1'b0};
    vecs[2]  = '{32'd4,  32'h00100593, 1'b0};
    vecs[3]  = '{32'd8,  32'h00A00613, 1'b0};
    vecs[4]  = '{32'd12, 32'h00060C63, 1'b0};
    vecs[5]  = '{32'd16, 32'h00B502B3, 1'b0};
    vecs[6]  = '{32'd20, 32'h00B00533, 1'b0};
    vecs[7]  = '{32'd24, 32'h005005B3, 1'b0};
    vecs[8]  = '{32'd28, 32'hFFF60613, 1'b0};
    vecs[9]  = '{32'd32, 32'hFEDFF06F, 1'b0};
    vecs[10] = '{32'd40, 32'h00000000, 1'b0};
    vecs[11] = '{32'h2,  32'h00000000, 1'b1};
    vecs[12] = '{32'h1000, 32'h00000000, 1'b1};

    step(); step();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    wait_clear("boot");

    // Fixed program image, back-to-back; first table entry fetches in the cycle right after ld_last.
    src = '{32'h00000513, 32'h00100593, 32'h00A00613, 32'h00060C63, 32'h00B502B3,
            32'h00B00533, 32'h005005B3, 32'hFFF60613, 32'hFEDFF06F, 32'h0000006F};
    load_src(0);
    chk("img_load_count", 32'(load_count), 32'd10);
    chk("img_boot_done",  32'(boot_done),  32'h1);
    chk("img_ld_ready",   32'(ld_ready),   32'h0);
    chk("img_load_ovf",   32'(load_ovf),   32'h0);
    for (int i = 0; i < 13; i++)
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err);
    fetch_req = 1'b0;
    step();
    chk("hold_rdata", fetch_rdata, exp_hold);
    chk("hold_valid", 32'(fetch_valid), 32'h0);
    rand_fetch(40);

    // Reload together with a fetch: the fetch sees pre-clear data.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    reload     = 1'b1;
    step();
    fetch_req = 1'b0;
    reload    = 1'b0;
    model_clear();
    chk("rl_fetch_valid", 32'(fetch_valid), 32'h1);
    chk("rl_fetch_rdata", fetch_rdata, 32'h00000513);
    chk("rl_boot_done",   32'(boot_done),  32'h0);
    chk("rl_load_count",  32'(load_count), 32'h0);
    exp_hold = 32'h00000513;
    wait_clear("reload1");

    // Gapped load of 5 words.
    src.delete();
    for (int i = 0; i < 5; i++) src.push_back($urandom);
    load_src(1);
    chk("gap_load_count", 32'(load_count), 32'd5);
    for (int i = 0; i < 6; i++)
      do_fetch($sformatf("gap_w%0d", i), 32'(i * 4), ref_word(i), 1'b0);
    rand_fetch(60);

    // Random-length image with random gaps.
    do_reload();
    wait_clear("reload2");
    src.delete();
    for (int i = 0; i < int'($urandom_range(1, 40)); i++) src.push_back($urandom);
    load_src(2);
    chk("rnd_load_count", 32'(load_count), 32'(image.size()));
    chk("rnd_boot_done",  32'(boot_done),  32'h1);
    rand_fetch(300);

    // Overflow: 1025 beats.
    do_reload();
    wait_clear("reload3");
    src.delete();
    for (int i = 0; i < 1025; i++) src.push_back($urandom);
    load_src(0);
    chk("ovf_flag",       32'(load_ovf),   32'(ovf_m));
    chk("ovf_load_count", 32'(load_count), 32'd1024);
    chk("ovf_boot_done",  32'(boot_done),  32'h1);
    do_fetch("ovf_w0",    32'd0,    src[0],    1'b0);
    do_fetch("ovf_w1023", 32'd4092, src[1023], 1'b0);
    do_fetch("ovf_oor",   32'd4096, 32'h0,     1'b1);
    rand_fetch(100);

    // Reset asserted mid-load.
    do_reload();
    wait_clear("reload4");
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      step();
    end
    ld_valid = 1'b0;
    chk("midld_count", 32'(load_count), 32'd3);
    rst_n = 1'b0;
    #1;
    exp_hold = 32'h0;
    model_clear();
    chk_reset_outs("midrst");
    step();
    rst_n = 1'b1;
    wait_clear("post_rst");
    src = '{32'hCAFE0001, 32'hCAFE0002};
    load_src(0);
    chk("post_rst_count", 32'(load_count), 32'd2);
    rand_fetch(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
